// File: rtl/hs_arb_pkg.sv
// Shared defaults and types for the handshake round-robin arbiter.
// The source-index width is derived from the requester count in a single place.
package hs_arb_pkg;
    localparam int DEF_N_REQ = 4;
    localparam int DEF_WIDTH = 8;

    function automatic int src_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_SRC_W = src_width(DEF_N_REQ);

    typedef logic [DEF_SRC_W-1:0] src_idx_t;
    typedef logic [DEF_N_REQ-1:0] grant_t;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first set request at or after
// ptr, wrapping around, as a one-hot grant and as an encoded index.
module rr_pick
    import hs_arb_pkg::*;
#(
    parameter  int N  = DEF_N_REQ,
    localparam int SW = src_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [SW-1:0] idx
);
    logic [2*N-1:0] req_dbl;
    logic [2*N-1:0] masked;
    logic           found;

    // Doubling the vector lets a plain low-to-high search handle the wrap.
    always_comb begin
        req_dbl = {req, req};
        masked  = req_dbl & ({(2*N){1'b1}} << ptr);
        grant   = '0;
        idx     = '0;
        found   = 1'b0;
        for (int i = 0; i < 2*N; i++) begin
            if (!found && masked[i]) begin
                found        = 1'b1;
                grant[i % N] = 1'b1;
                idx          = SW'(i % N);
            end
        end
    end
endmodule

// File: rtl/hs_rr_arbiter.sv
// Round-robin arbiter sharing one valid/ready channel between N_REQ masters,
// with a registered output stage that holds its beat under backpressure.
module hs_rr_arbiter
    import hs_arb_pkg::*;
#(
    parameter  int N_REQ = DEF_N_REQ,
    parameter  int WIDTH = DEF_WIDTH,
    localparam int SRC_W = src_width(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    output logic [SRC_W-1:0]       out_src,
    input  logic                   out_ready
);
    logic [SRC_W-1:0] ptr;
    logic [SRC_W-1:0] g_idx;
    logic [N_REQ-1:0] grant;
    logic [WIDTH-1:0] lane_sel;
    logic             can_load;
    logic             accept;

    rr_pick #(.N(N_REQ)) u_pick (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (g_idx)
    );

    // Loading is allowed when the stage is empty or is draining this cycle.
    assign can_load  = !out_valid || out_ready;
    assign req_ready = (can_load && !rst) ? grant : '0;
    assign accept    = |(req_valid & req_ready);
    assign lane_sel  = req_data[g_idx*WIDTH +: WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            ptr       <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= lane_sel;
            out_src   <= g_idx;
            ptr       <= (g_idx == SRC_W'(N_REQ-1)) ? '0 : g_idx + 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_hs_rr_arbiter.sv
// Self-checking bench for hs_rr_arbiter: directed scenarios plus a randomized
// run against a rotating-priority reference model.
module tb_hs_rr_arbiter;
    import hs_arb_pkg::*;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0]   req_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [1:0]     out_src;
    logic           out_ready = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    int         m_ptr;
    bit         m_valid;
    logic [W-1:0] m_data;
    int         m_src;
    int         last_acc;

    hs_rr_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    function automatic int m_pick(input logic [N-1:0] v);
        for (int k = 0; k < N; k++)
            if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    function automatic logic [N-1:0] m_ready();
        int g;
        logic [N-1:0] r;
        g = m_pick(req_valid);
        r = '0;
        if (!rst && g >= 0 && (!m_valid || out_ready)) r[g] = 1'b1;
        return r;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_valid = 0; m_data = '0; m_src = 0;
    endtask

    task automatic tick();
        int g;
        logic [W-1:0] lane;
        bit ro;
        g = m_pick(req_valid);
        last_acc = -1;
        lane = '0;
        ro = out_ready;
        if (!rst && g >= 0 && (!m_valid || out_ready)) begin
            last_acc = g;
            lane = req_data[g*W +: W];
        end
        @(posedge clk);
        if (last_acc >= 0) begin
            m_valid = 1; m_data = lane; m_src = last_acc; m_ptr = (last_acc + 1) % N;
        end else if (ro) begin
            m_valid = 0;
        end
        #1;
    endtask

    task automatic drive(input logic [N-1:0] v, input logic ro);
        @(negedge clk);
        req_valid = v;
        out_ready = ro;
    endtask

    task automatic set_lane(input int i, input logic [W-1:0] d);
        req_data[i*W +: W] = d;
    endtask

    task automatic test_reset();
        req_valid = '1; out_ready = 1'b1; req_data = '0;
        #1 rst = 1'b1;
        model_reset();
        repeat (2) begin
            @(negedge clk); #1;
            vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
            vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", out_valid); end
            vectors++; if (out_src !== 2'd0) begin miscompares++; $display("FAIL reset_src: got %0d want 0", out_src); end
        end
        @(negedge clk);
        rst = 1'b0; req_valid = '0;
        repeat (5) begin
            tick();
            vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL idle_after_reset: out_valid got %b want 0", out_valid); end
        end
    endtask

    task automatic test_full_contention();
        logic [N-1:0] exp_r;
        drive('1, 1'b1);
        for (int i = 0; i < N; i++) set_lane(i, W'(8'h10 + i));
        for (int k = 0; k < 8; k++) begin
            #1;
            exp_r = '0; exp_r[k % N] = 1'b1;
            vectors++; if (req_ready !== exp_r) begin miscompares++; $display("FAIL contention_ready[%0d]: got %b want %b", k, req_ready, exp_r); end
            tick();
            vectors++; if (out_valid !== 1'b1 || out_data !== W'(8'h10 + k % N)) begin
                miscompares++; $display("FAIL contention_beat[%0d]: got v=%b d=%h want v=1 d=%h", k, out_valid, out_data, 8'h10 + k % N); end
        end
    endtask

    task automatic test_backpressure();
        drive(4'b0001, 1'b1);
        set_lane(0, 8'h10);
        tick();
        vectors++; if (out_valid !== 1'b1 || out_data !== 8'h10 || out_src !== 2'd0) begin
            miscompares++; $display("FAIL bp_setup: got v=%b d=%h s=%0d want 1 10 0", out_valid, out_data, out_src); end
        drive(4'b0010, 1'b0);
        set_lane(1, 8'h11);
        repeat (3) begin
            #1;
            vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL bp_ready: got %b want 0000", req_ready); end
            tick();
            vectors++; if (out_valid !== 1'b1 || out_data !== 8'h10 || out_src !== 2'd0) begin
                miscompares++; $display("FAIL bp_hold: got v=%b d=%h s=%0d want 1 10 0", out_valid, out_data, out_src); end
        end
        drive(4'b0010, 1'b1);
        #1;
        vectors++; if (req_ready !== 4'b0010) begin miscompares++; $display("FAIL bp_release_ready: got %b want 0010", req_ready); end
        tick();
        vectors++; if (out_data !== 8'h11 || out_src !== 2'd1) begin
            miscompares++; $display("FAIL bp_release_beat: got d=%h s=%0d want 11 1", out_data, out_src); end
    endtask

    task automatic test_single();
        drive(4'b0100, 1'b1);
        set_lane(2, 8'h5A);
        #1;
        vectors++; if (req_ready !== 4'b0100) begin miscompares++; $display("FAIL single_ready: got %b want 0100", req_ready); end
        tick();
        vectors++; if (out_valid !== 1'b1 || out_data !== 8'h5A || out_src !== 2'd2) begin
            miscompares++; $display("FAIL single_beat: got v=%b d=%h s=%0d want 1 5a 2", out_valid, out_data, out_src); end
    endtask

    task automatic test_wraparound();
        drive(4'b1001, 1'b1);
        set_lane(0, 8'h20); set_lane(3, 8'h23);
        #1;
        vectors++; if (req_ready !== 4'b1000) begin miscompares++; $display("FAIL wrap_ready_first: got %b want 1000", req_ready); end
        tick();
        vectors++; if (out_data !== 8'h23 || out_src !== 2'd3) begin miscompares++; $display("FAIL wrap_beat_first: got d=%h s=%0d want 23 3", out_data, out_src); end
        drive(4'b0001, 1'b1);
        #1;
        vectors++; if (req_ready !== 4'b0001) begin miscompares++; $display("FAIL wrap_ready_second: got %b want 0001", req_ready); end
        tick();
        vectors++; if (out_data !== 8'h20 || out_src !== 2'd0) begin miscompares++; $display("FAIL wrap_beat_second: got d=%h s=%0d want 20 0", out_data, out_src); end
        // With the pointer now at 1, requester 1 must beat requester 0.
        drive(4'b0011, 1'b1);
        set_lane(1, 8'h21);
        #1;
        vectors++; if (req_ready !== 4'b0010) begin miscompares++; $display("FAIL wrap_ptr_one: got %b want 0010", req_ready); end
        tick();
        drive(4'b0000, 1'b0);
        tick();
        vectors++; if (out_valid !== 1'b1 || out_src !== 2'd1) begin miscompares++; $display("FAIL wrap_stall_hold: got v=%b s=%0d want 1 1", out_valid, out_src); end
    endtask

    task automatic test_reset_mid();
        #3;
        rst = 1'b1; req_valid = 4'b0001; out_ready = 1'b1;
        model_reset();
        #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_valid: got %b want 0", out_valid); end
        vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL midrst_ready: got %b want 0000", req_ready); end
        @(negedge clk);
        rst = 1'b0;
        set_lane(0, 8'h44);
        #1;
        vectors++; if (out_valid !== 1'b0 || req_ready !== 4'b0001) begin
            miscompares++; $display("FAIL midrst_release: got v=%b r=%b want 0 0001", out_valid, req_ready); end
        tick();
        vectors++; if (out_valid !== 1'b1 || out_src !== 2'd0 || out_data !== 8'h44) begin
            miscompares++; $display("FAIL midrst_first: got v=%b s=%0d d=%h want 1 0 44", out_valid, out_src, out_data); end
        drive(4'b0010, 1'b1);
        set_lane(1, 8'h55);
        tick();
        vectors++; if (out_src !== 2'd1 || out_data !== 8'h55) begin
            miscompares++; $display("FAIL midrst_next: got s=%0d d=%h want 1 55", out_src, out_data); end
    endtask

    task automatic test_random();
        logic [N-1:0] exp_r;
        drive('0, 1'b1);
        tick();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(1, 0) == 1) begin
                    req_valid[i] = 1'b1;
                    set_lane(i, W'($urandom));
                end
            end
            out_ready = ($urandom_range(3, 0) != 0);
            #1;
            exp_r = m_ready();
            vectors++; if (req_ready !== exp_r) begin miscompares++; $display("FAIL rand_ready[%0d]: got %b want %b", c, req_ready, exp_r); end
            tick();
            vectors++; if (out_valid !== m_valid || out_data !== m_data || out_src !== 2'(m_src)) begin
                miscompares++;
                $display("FAIL rand_out[%0d]: got v=%b d=%h s=%0d want v=%b d=%h s=%0d", c, out_valid, out_data, out_src, m_valid, m_data, m_src);
            end
            if (last_acc >= 0) req_valid[last_acc] = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_full_contention();
        test_backpressure();
        test_single();
        test_wraparound();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
